// File: rtl/fwd_dest_pipe.sv
`default_nettype none
// ============================================================================
// fwd_dest_pipe : EX/MEM/WB destination tracking for forwarding, load-use
//                 bubble insertion and freeze statistics.
// Revision      : 1.0
// ============================================================================
module fwd_dest_pipe #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_wr,
   input  logic [3:0]       id_dest,
   input  logic             id_load,
   input  logic             freeze,
   input  logic             flush,
   output logic             wr1,
   output logic             wr2,
   output logic             wr3,
   output logic [3:0]       match_add1,
   output logic [3:0]       match_add2,
   output logic [3:0]       match_add3,
   output logic             load,
   output logic             hold_fetch,
   output logic [CNT_W-1:0] freeze_cnt,
   output logic             freeze_err
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic             w_bubble;
   logic             r_s1_wr;
   logic             r_s2_wr;
   logic             r_s3_wr;
   logic [3:0]       r_s1_dest;
   logic [3:0]       r_s2_dest;
   logic [3:0]       r_s3_dest;
   logic             r_s1_ld;
   logic [CNT_W-1:0] r_freeze_cnt;
   logic [1:0]       r_consec;
   logic             r_freeze_err;

   assign w_bubble = freeze | flush | ~id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_wr   <= 1'b0;
         r_s2_wr   <= 1'b0;
         r_s3_wr   <= 1'b0;
         r_s1_dest <= 4'h0;
         r_s2_dest <= 4'h0;
         r_s3_dest <= 4'h0;
         r_s1_ld   <= 1'b0;
      end else begin
         r_s3_wr   <= r_s2_wr;
         r_s3_dest <= r_s2_dest;
         r_s2_wr   <= r_s1_wr;
         r_s2_dest <= r_s1_dest;
         if (w_bubble) begin
            r_s1_wr   <= 1'b0;
            r_s1_dest <= 4'h0;
            r_s1_ld   <= 1'b0;
         end else begin
            r_s1_wr   <= id_wr;
            r_s1_dest <= id_dest;
            r_s1_ld   <= id_load & id_wr;
         end
      end
   end

   // Run-length counter only needs to distinguish 0,1,2 and "more".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_freeze_cnt <= '0;
         r_consec     <= 2'd0;
         r_freeze_err <= 1'b0;
      end else begin
         if (freeze && (r_freeze_cnt != c_cnt_max)) begin
            r_freeze_cnt <= r_freeze_cnt + 1'b1;
         end
         if (!freeze) begin
            r_consec <= 2'd0;
         end else if (r_consec != 2'd3) begin
            r_consec <= r_consec + 2'd1;
         end
         if (freeze && (r_consec == 2'd2)) begin
            r_freeze_err <= 1'b1;
         end
      end
   end

   assign wr1        = r_s1_wr;
   assign wr2        = r_s2_wr;
   assign wr3        = r_s3_wr;
   assign match_add1 = r_s1_dest;
   assign match_add2 = r_s2_dest;
   assign match_add3 = r_s3_dest;
   assign load       = r_s1_wr & r_s1_ld;
   assign hold_fetch = freeze & ~flush;
   assign freeze_cnt = r_freeze_cnt;
   assign freeze_err = r_freeze_err;

endmodule
`default_nettype wire

// File: tb/tb_fwd_dest_pipe.sv
`default_nettype none
// ============================================================================
// tb_fwd_dest_pipe : directed stimulus, slot-history model and per-cycle compare
// Revision         : 1.0
// ============================================================================
module tb_fwd_dest_pipe;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic       id_wr;
   logic [3:0] id_dest;
   logic       id_load;
   logic       freeze;
   logic       flush;

   logic       wr1, wr2, wr3, load, hold_fetch, freeze_err;
   logic [3:0] match_add1, match_add2, match_add3;
   logic [7:0] freeze_cnt;

   logic       b_wr1, b_wr2, b_wr3, b_load, b_hold_fetch, b_freeze_err;
   logic [3:0] b_match_add1, b_match_add2, b_match_add3;
   logic [1:0] b_freeze_cnt;

   fwd_dest_pipe #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_wr(id_wr),
      .id_dest(id_dest), .id_load(id_load), .freeze(freeze), .flush(flush),
      .wr1(wr1), .wr2(wr2), .wr3(wr3),
      .match_add1(match_add1), .match_add2(match_add2), .match_add3(match_add3),
      .load(load), .hold_fetch(hold_fetch), .freeze_cnt(freeze_cnt),
      .freeze_err(freeze_err)
   );

   fwd_dest_pipe #(.CNT_W(2)) dut_narrow (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_wr(id_wr),
      .id_dest(id_dest), .id_load(id_load), .freeze(freeze), .flush(flush),
      .wr1(b_wr1), .wr2(b_wr2), .wr3(b_wr3),
      .match_add1(b_match_add1), .match_add2(b_match_add2), .match_add3(b_match_add3),
      .load(b_load), .hold_fetch(b_hold_fetch), .freeze_cnt(b_freeze_cnt),
      .freeze_err(b_freeze_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: history of what entered the EX slot, total and run-length freeze counts.
   typedef struct packed {
      logic       wr;
      logic [3:0] dest;
      logic       ld;
   } slot_t;

   slot_t m_hist [3];
   slot_t m_new;
   int    m_nfrz;
   int    m_run;
   logic  m_err;

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) m_hist[i] = '0;
         m_nfrz = 0;
         m_run  = 0;
         m_err  = 1'b0;
      end else begin
         m_new = '0;
         if (id_valid && !freeze && !flush) begin
            m_new.wr   = id_wr;
            m_new.dest = id_dest;
            m_new.ld   = id_load && id_wr;
         end
         m_hist[2] = m_hist[1];
         m_hist[1] = m_hist[0];
         m_hist[0] = m_new;
         if (freeze) begin
            m_nfrz++;
            m_run++;
            if (m_run >= 3) m_err = 1'b1;
         end else begin
            m_run = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("wr1", wr1, m_hist[0].wr);
      chk("wr2", wr2, m_hist[1].wr);
      chk("wr3", wr3, m_hist[2].wr);
      chk("match_add1", match_add1, m_hist[0].dest);
      chk("match_add2", match_add2, m_hist[1].dest);
      chk("match_add3", match_add3, m_hist[2].dest);
      chk("load", load, m_hist[0].wr & m_hist[0].ld);
      chk("hold_fetch", hold_fetch, freeze & ~flush);
      chk("freeze_cnt", freeze_cnt, sat(m_nfrz, 8));
      chk("freeze_cnt_w2", b_freeze_cnt, sat(m_nfrz, 2));
      chk("freeze_err", freeze_err, m_err);
      chk("freeze_err_w2", b_freeze_err, m_err);
   end

   task automatic step(input logic v, input logic w, input logic [3:0] d,
                       input logic l, input logic f, input logic fl);
      id_valid = v;
      id_wr    = w;
      id_dest  = d;
      id_load  = l;
      freeze   = f;
      flush    = fl;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr1"}, wr1, 0);
      chk({tag, "_wr2"}, wr2, 0);
      chk({tag, "_wr3"}, wr3, 0);
      chk({tag, "_add1"}, match_add1, 0);
      chk({tag, "_add2"}, match_add2, 0);
      chk({tag, "_add3"}, match_add3, 0);
      chk({tag, "_load"}, load, 0);
      chk({tag, "_cnt"}, freeze_cnt, 0);
      chk({tag, "_err"}, freeze_err, 0);
   endtask

   // {valid, wr, dest[3:0], load, freeze, flush}
   logic [8:0] tbl [7];
   logic [1:0] exp_narrow [6];

   initial begin
      tbl[0] = 9'b1_0_0110_1_0_0;
      tbl[1] = 9'b1_1_1000_1_0_1;
      tbl[2] = 9'b0_1_1001_0_0_0;
      tbl[3] = 9'b1_1_1111_1_0_0;
      tbl[4] = 9'b1_1_0010_0_0_0;
      tbl[5] = 9'b0_0_0000_0_1_0;
      tbl[6] = 9'b1_1_1110_0_0_0;
      exp_narrow[0] = 2'd1; exp_narrow[1] = 2'd2; exp_narrow[2] = 2'd3;
      exp_narrow[3] = 2'd3; exp_narrow[4] = 2'd3; exp_narrow[5] = 2'd3;

      rst_n    = 1'b0;
      id_valid = 1'b0;
      id_wr    = 1'b0;
      id_dest  = 4'h0;
      id_load  = 1'b0;
      freeze   = 1'b0;
      flush    = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Single write to R5 walks through EX, MEM, WB.
      step(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
      chk("p1_add1", match_add1, 5);
      chk("p1_wr1", wr1, 1);
      idle();
      chk("p2_add2", match_add2, 5);
      chk("p2_wr1", wr1, 0);
      idle();
      chk("p3_add3", match_add3, 5);
      chk("p3_wr3", wr3, 1);
      idle();
      chk("p4_wr3", wr3, 0);

      // Load to R3 followed by one freeze cycle.
      step(1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
      chk("lu_load", load, 1);
      chk("lu_add1", match_add1, 3);
      step(1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
      chk("lu_hold", hold_fetch, 1);
      chk("lu_wr1", wr1, 0);
      chk("lu_wr2", wr2, 1);
      chk("lu_add2", match_add2, 3);
      chk("lu_load_off", load, 0);
      chk("lu_cnt", freeze_cnt, 1);
      idle();
      idle();

      // Freeze and flush together.
      step(1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      chk("ff_hold", hold_fetch, 0);
      chk("ff_wr1", wr1, 0);
      chk("ff_cnt", freeze_cnt, 2);
      idle();
      idle();

      for (int i = 0; i < 7; i++) begin
         step(tbl[i][8], tbl[i][7], tbl[i][6:3], tbl[i][2], tbl[i][1], tbl[i][0]);
      end
      idle();

      // Fill all slots, then reset between edges.
      step(1'b1, 1'b1, 4'ha, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'hb, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'hc, 1'b1, 1'b0, 1'b0);
      chk("fill_wr3", wr3, 1);
      chk("fill_load", load, 1);
      id_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk_all_zero("async");
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
      chk("post_add1", match_add1, 9);
      chk("post_wr2", wr2, 0);
      chk("post_wr3", wr3, 0);

      // Sustained freeze: narrow counter saturates, error sets on the third cycle.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
         chk("sat_cnt_w2", b_freeze_cnt, exp_narrow[i]);
         chk("sat_cnt", freeze_cnt, i + 1);
         chk("sat_err", freeze_err, (i >= 2) ? 1 : 0);
      end
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("sticky_err", freeze_err, 1);
      end

      rst_n = 1'b0;
      #1;
      chk("rst_err", freeze_err, 0);
      chk("rst_cnt_w2", b_freeze_cnt, 0);
      #1;
      rst_n = 1'b1;
      idle();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
